// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter that shares one simple register interface.
// Each transaction gets a bounded lifetime through a saturating timeout counter.
module reg_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic [ADDR_WIDTH-1:0] i_m0_reg_address,
  input  logic                  i_m0_reg_in_rdy,
  input  logic [DATA_WIDTH-1:0] i_m0_reg_in_data,
  output logic                  o_m0_reg_in_ack_stb,
  input  logic                  i_m0_reg_out_req,
  output logic                  o_m0_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0] o_m0_reg_out_data,
  output logic                  o_m0_reg_invalid_addr,
  // master 1
  input  logic [ADDR_WIDTH-1:0] i_m1_reg_address,
  input  logic                  i_m1_reg_in_rdy,
  input  logic [DATA_WIDTH-1:0] i_m1_reg_in_data,
  output logic                  o_m1_reg_in_ack_stb,
  input  logic                  i_m1_reg_out_req,
  output logic                  o_m1_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0] o_m1_reg_out_data,
  output logic                  o_m1_reg_invalid_addr,
  // downstream register bank
  output logic [ADDR_WIDTH-1:0] o_reg_address,
  output logic                  o_reg_in_rdy,
  output logic [DATA_WIDTH-1:0] o_reg_in_data,
  input  logic                  i_reg_in_ack_stb,
  output logic                  o_reg_out_req,
  input  logic                  i_reg_out_rdy_stb,
  input  logic [DATA_WIDTH-1:0] i_reg_out_data,
  input  logic                  i_reg_invalid_addr,
  // status
  output logic [1:0]            o_grant,
  output logic                  o_timeout_stb
);

  // A zero timeout still needs a legal one-bit counter; the compare is gated off.
  localparam int unsigned    CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam bit             TMO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                r_state, w_state;
  logic                  r_last, w_last;       // 1: m1 was granted last
  logic                  r_owner, w_owner;     // 1: m1 owns the bus
  logic                  r_is_write, w_is_write;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [1:0]            r_grant, w_grant;
  logic [ADDR_WIDTH-1:0] r_reg_address, w_reg_address;
  logic [DATA_WIDTH-1:0] r_reg_in_data, w_reg_in_data;
  logic                  r_reg_in_rdy, w_reg_in_rdy;
  logic                  r_reg_out_req, w_reg_out_req;
  logic                  r_m0_in_ack, w_m0_in_ack;
  logic                  r_m0_out_rdy, w_m0_out_rdy;
  logic [DATA_WIDTH-1:0] r_m0_out_data, w_m0_out_data;
  logic                  r_m0_inv, w_m0_inv;
  logic                  r_m1_in_ack, w_m1_in_ack;
  logic                  r_m1_out_rdy, w_m1_out_rdy;
  logic [DATA_WIDTH-1:0] r_m1_out_data, w_m1_out_data;
  logic                  r_m1_inv, w_m1_inv;
  logic                  r_timeout, w_timeout;

  // transaction completion, routed to the owning master
  logic                  w_fin;
  logic                  w_fin_inv;
  logic [DATA_WIDTH-1:0] w_fin_data;

  logic                  w_m0_req, w_m1_req;
  logic                  w_sel;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_match;

  // Request decode and round-robin pick (m1 wins unless m0 has the turn or is alone).
  assign w_m0_req   = i_m0_reg_in_rdy | i_m0_reg_out_req;
  assign w_m1_req   = i_m1_reg_in_rdy | i_m1_reg_out_req;
  assign w_sel      = ~(w_m0_req & (~w_m1_req | r_last));
  assign w_sel_wr   = w_sel ? i_m1_reg_in_rdy  : i_m0_reg_in_rdy;
  assign w_sel_addr = w_sel ? i_m1_reg_address : i_m0_reg_address;
  assign w_sel_data = w_sel ? i_m1_reg_in_data : i_m0_reg_in_data;
  assign w_match    = r_is_write ? i_reg_in_ack_stb : i_reg_out_rdy_stb;

  // Next-state and next-output logic.
  always_comb begin
    w_state       = r_state;
    w_last        = r_last;
    w_owner       = r_owner;
    w_is_write    = r_is_write;
    w_cnt         = r_cnt;
    w_grant       = r_grant;
    w_reg_address = r_reg_address;
    w_reg_in_data = r_reg_in_data;
    w_reg_in_rdy  = r_reg_in_rdy;
    w_reg_out_req = r_reg_out_req;
    w_m0_in_ack   = 1'b0;
    w_m0_out_rdy  = 1'b0;
    w_m0_out_data = r_m0_out_data;
    w_m0_inv      = 1'b0;
    w_m1_in_ack   = 1'b0;
    w_m1_out_rdy  = 1'b0;
    w_m1_out_data = r_m1_out_data;
    w_m1_inv      = 1'b0;
    w_timeout     = 1'b0;
    w_fin         = 1'b0;
    w_fin_inv     = 1'b0;
    w_fin_data    = '0;

    case (r_state)
      S_IDLE: begin
        if (w_m0_req | w_m1_req) begin
          w_state       = S_GRANT;
          w_last        = w_sel;
          w_owner       = w_sel;
          w_is_write    = w_sel_wr;
          w_cnt         = '0;
          w_grant       = w_sel ? 2'b10 : 2'b01;
          w_reg_address = w_sel_addr;
          w_reg_in_data = w_sel_data;
          w_reg_in_rdy  = w_sel_wr;
          w_reg_out_req = ~w_sel_wr;
        end
      end
      S_GRANT: begin
        if (w_match) begin
          w_fin      = 1'b1;
          w_fin_inv  = i_reg_invalid_addr;
          w_fin_data = i_reg_out_data;
        end else if (TMO_EN && (r_cnt == CNT_LIMIT)) begin
          w_fin      = 1'b1;
          w_fin_inv  = 1'b1;
          w_fin_data = '0;
          w_timeout  = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt = r_cnt + CNT_W'(1);
        end
        if (w_fin) begin
          w_state       = S_RELEASE;
          w_grant       = 2'b00;
          w_reg_in_rdy  = 1'b0;
          w_reg_out_req = 1'b0;
        end
      end
      S_RELEASE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state       = S_IDLE;
        w_grant       = 2'b00;
        w_reg_in_rdy  = 1'b0;
        w_reg_out_req = 1'b0;
      end
    endcase

    if (w_fin) begin
      if (r_owner) begin
        w_m1_inv = w_fin_inv;
        if (r_is_write) begin
          w_m1_in_ack = 1'b1;
        end else begin
          w_m1_out_rdy  = 1'b1;
          w_m1_out_data = w_fin_data;
        end
      end else begin
        w_m0_inv = w_fin_inv;
        if (r_is_write) begin
          w_m0_in_ack = 1'b1;
        end else begin
          w_m0_out_rdy  = 1'b1;
          w_m0_out_data = w_fin_data;
        end
      end
    end
  end

  // FSM state, round-robin pointer and transaction context.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_is_write <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state;
      r_last     <= w_last;
      r_owner    <= w_owner;
      r_is_write <= w_is_write;
      r_cnt      <= w_cnt;
    end
  end

  // Registered outputs toward both masters and the register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant       <= '0;
      r_reg_address <= '0;
      r_reg_in_data <= '0;
      r_reg_in_rdy  <= 1'b0;
      r_reg_out_req <= 1'b0;
      r_m0_in_ack   <= 1'b0;
      r_m0_out_rdy  <= 1'b0;
      r_m0_out_data <= '0;
      r_m0_inv      <= 1'b0;
      r_m1_in_ack   <= 1'b0;
      r_m1_out_rdy  <= 1'b0;
      r_m1_out_data <= '0;
      r_m1_inv      <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_grant       <= w_grant;
      r_reg_address <= w_reg_address;
      r_reg_in_data <= w_reg_in_data;
      r_reg_in_rdy  <= w_reg_in_rdy;
      r_reg_out_req <= w_reg_out_req;
      r_m0_in_ack   <= w_m0_in_ack;
      r_m0_out_rdy  <= w_m0_out_rdy;
      r_m0_out_data <= w_m0_out_data;
      r_m0_inv      <= w_m0_inv;
      r_m1_in_ack   <= w_m1_in_ack;
      r_m1_out_rdy  <= w_m1_out_rdy;
      r_m1_out_data <= w_m1_out_data;
      r_m1_inv      <= w_m1_inv;
      r_timeout     <= w_timeout;
    end
  end

  assign o_grant               = r_grant;
  assign o_reg_address         = r_reg_address;
  assign o_reg_in_data         = r_reg_in_data;
  assign o_reg_in_rdy          = r_reg_in_rdy;
  assign o_reg_out_req         = r_reg_out_req;
  assign o_m0_reg_in_ack_stb   = r_m0_in_ack;
  assign o_m0_reg_out_rdy_stb  = r_m0_out_rdy;
  assign o_m0_reg_out_data     = r_m0_out_data;
  assign o_m0_reg_invalid_addr = r_m0_inv;
  assign o_m1_reg_in_ack_stb   = r_m1_in_ack;
  assign o_m1_reg_out_rdy_stb  = r_m1_out_rdy;
  assign o_m1_reg_out_data     = r_m1_out_data;
  assign o_m1_reg_invalid_addr = r_m1_inv;
  assign o_timeout_stb         = r_timeout;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with a short timeout.
module tb_reg_bus_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] i_m0_reg_address, i_m1_reg_address;
  logic          i_m0_reg_in_rdy, i_m1_reg_in_rdy;
  logic [DW-1:0] i_m0_reg_in_data, i_m1_reg_in_data;
  logic          o_m0_reg_in_ack_stb, o_m1_reg_in_ack_stb;
  logic          i_m0_reg_out_req, i_m1_reg_out_req;
  logic          o_m0_reg_out_rdy_stb, o_m1_reg_out_rdy_stb;
  logic [DW-1:0] o_m0_reg_out_data, o_m1_reg_out_data;
  logic          o_m0_reg_invalid_addr, o_m1_reg_invalid_addr;
  logic [AW-1:0] o_reg_address;
  logic          o_reg_in_rdy;
  logic [DW-1:0] o_reg_in_data;
  logic          i_reg_in_ack_stb;
  logic          o_reg_out_req;
  logic          i_reg_out_rdy_stb;
  logic [DW-1:0] i_reg_out_data;
  logic          i_reg_invalid_addr;
  logic [1:0]    o_grant;
  logic          o_timeout_stb;

  int n_checks;
  int n_errors;
  int overlap_cnt;
  int m0_ack_cnt;
  int m1_ack_cnt;
  int m1_rd_cnt;
  int snap0, snap1, snap_ov;

  reg_bus_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_m0_reg_address     (i_m0_reg_address),
    .i_m0_reg_in_rdy      (i_m0_reg_in_rdy),
    .i_m0_reg_in_data     (i_m0_reg_in_data),
    .o_m0_reg_in_ack_stb  (o_m0_reg_in_ack_stb),
    .i_m0_reg_out_req     (i_m0_reg_out_req),
    .o_m0_reg_out_rdy_stb (o_m0_reg_out_rdy_stb),
    .o_m0_reg_out_data    (o_m0_reg_out_data),
    .o_m0_reg_invalid_addr(o_m0_reg_invalid_addr),
    .i_m1_reg_address     (i_m1_reg_address),
    .i_m1_reg_in_rdy      (i_m1_reg_in_rdy),
    .i_m1_reg_in_data     (i_m1_reg_in_data),
    .o_m1_reg_in_ack_stb  (o_m1_reg_in_ack_stb),
    .i_m1_reg_out_req     (i_m1_reg_out_req),
    .o_m1_reg_out_rdy_stb (o_m1_reg_out_rdy_stb),
    .o_m1_reg_out_data    (o_m1_reg_out_data),
    .o_m1_reg_invalid_addr(o_m1_reg_invalid_addr),
    .o_reg_address        (o_reg_address),
    .o_reg_in_rdy         (o_reg_in_rdy),
    .o_reg_in_data        (o_reg_in_data),
    .i_reg_in_ack_stb     (i_reg_in_ack_stb),
    .o_reg_out_req        (o_reg_out_req),
    .i_reg_out_rdy_stb    (i_reg_out_rdy_stb),
    .i_reg_out_data       (i_reg_out_data),
    .i_reg_invalid_addr   (i_reg_invalid_addr),
    .o_grant              (o_grant),
    .o_timeout_stb        (o_timeout_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe and grant-overlap counters sampled mid-cycle.
  always @(negedge clk) begin
    if (o_grant == 2'b11)     overlap_cnt++;
    if (o_m0_reg_in_ack_stb)  m0_ack_cnt++;
    if (o_m1_reg_in_ack_stb)  m1_ack_cnt++;
    if (o_m1_reg_out_rdy_stb) m1_rd_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    overlap_cnt = 0; m0_ack_cnt = 0; m1_ack_cnt = 0; m1_rd_cnt = 0;
    rst = 1'b1;
    i_m0_reg_address = '0; i_m0_reg_in_rdy = 1'b0; i_m0_reg_in_data = '0; i_m0_reg_out_req = 1'b0;
    i_m1_reg_address = '0; i_m1_reg_in_rdy = 1'b0; i_m1_reg_in_data = '0; i_m1_reg_out_req = 1'b0;
    i_reg_in_ack_stb = 1'b0; i_reg_out_rdy_stb = 1'b0; i_reg_out_data = '0; i_reg_invalid_addr = 1'b0;

    // reset state
    tick(); tick();
    check("rst_grant",   64'(o_grant), 64'd0);
    check("rst_in_rdy",  64'(o_reg_in_rdy), 64'd0);
    check("rst_out_req", 64'(o_reg_out_req), 64'd0);
    check("rst_addr",    64'(o_reg_address), 64'd0);
    check("rst_wdata",   64'(o_reg_in_data), 64'd0);
    check("rst_tmo",     64'(o_timeout_stb), 64'd0);
    check("rst_m0_data", 64'(o_m0_reg_out_data), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_grant", 64'(o_grant), 64'd0);

    // single write from m0, bank acks one cycle after the request appears
    i_m0_reg_address = 32'h0; i_m0_reg_in_data = 32'hA5A5_0001; i_m0_reg_in_rdy = 1'b1;
    tick();
    check("wr_grant1", 64'(o_grant), 64'd1);
    check("wr_rdy1",   64'(o_reg_in_rdy), 64'd1);
    check("wr_data",   64'(o_reg_in_data), 64'hA5A5_0001);
    check("wr_addr",   64'(o_reg_address), 64'h0);
    tick();
    check("wr_grant2", 64'(o_grant), 64'd1);
    check("wr_rdy2",   64'(o_reg_in_rdy), 64'd1);
    check("wr_no_ack_yet", 64'(o_m0_reg_in_ack_stb), 64'd0);
    i_reg_in_ack_stb = 1'b1;
    tick();
    i_reg_in_ack_stb = 1'b0; i_m0_reg_in_rdy = 1'b0;
    check("wr_ack",    64'(o_m0_reg_in_ack_stb), 64'd1);
    check("wr_inv",    64'(o_m0_reg_invalid_addr), 64'd0);
    check("wr_grant3", 64'(o_grant), 64'd0);
    check("wr_rdy3",   64'(o_reg_in_rdy), 64'd0);
    tick();
    check("wr_ack_once", 64'(o_m0_reg_in_ack_stb), 64'd0);

    // m1 read that the bank flags as invalid
    i_m1_reg_address = 32'h8; i_m1_reg_out_req = 1'b1;
    tick();
    check("rd_grant", 64'(o_grant), 64'd2);
    check("rd_req",   64'(o_reg_out_req), 64'd1);
    check("rd_addr",  64'(o_reg_address), 64'h8);
    i_reg_out_rdy_stb = 1'b1; i_reg_out_data = 32'h0; i_reg_invalid_addr = 1'b1;
    tick();
    i_reg_out_rdy_stb = 1'b0; i_reg_invalid_addr = 1'b0; i_m1_reg_out_req = 1'b0;
    check("rd_stb",  64'(o_m1_reg_out_rdy_stb), 64'd1);
    check("rd_inv",  64'(o_m1_reg_invalid_addr), 64'd1);
    check("rd_data", 64'(o_m1_reg_out_data), 64'd0);
    check("rd_m0_quiet", 64'(o_m0_reg_out_rdy_stb), 64'd0);
    tick();
    check("rd_stb_once", 64'(o_m1_reg_out_rdy_stb), 64'd0);
    check("rd_inv_clear", 64'(o_m1_reg_invalid_addr), 64'd0);

    // contention: both masters always requesting when the arbiter decides
    i_m0_reg_address = 32'h100; i_m0_reg_in_data = 32'hC0DE_0000; i_m0_reg_in_rdy = 1'b1;
    i_m1_reg_address = 32'h200; i_m1_reg_in_data = 32'hC0DE_0001; i_m1_reg_in_rdy = 1'b1;
    snap0 = m0_ack_cnt; snap1 = m1_ack_cnt; snap_ov = overlap_cnt;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_grant", 64'(o_grant), (i % 2 == 0) ? 64'd1 : 64'd2);
      check("cont_addr",  64'(o_reg_address), (i % 2 == 0) ? 64'h100 : 64'h200);
      i_reg_in_ack_stb = 1'b1;
      tick();
      i_reg_in_ack_stb = 1'b0;
      check("cont_m0_ack", 64'(o_m0_reg_in_ack_stb), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("cont_m1_ack", 64'(o_m1_reg_in_ack_stb), (i % 2 == 0) ? 64'd0 : 64'd1);
      if (i % 2 == 0) i_m0_reg_in_rdy = 1'b0;
      else            i_m1_reg_in_rdy = 1'b0;
      if (i == 3) begin
        i_m0_reg_in_rdy = 1'b0; i_m1_reg_in_rdy = 1'b0;
      end
      tick();
      if (i < 3) begin
        if (i % 2 == 0) i_m0_reg_in_rdy = 1'b1;
        else            i_m1_reg_in_rdy = 1'b1;
      end
    end
    check("cont_m0_total", 64'(m0_ack_cnt - snap0), 64'd2);
    check("cont_m1_total", 64'(m1_ack_cnt - snap1), 64'd2);
    check("cont_overlap",  64'(overlap_cnt - snap_ov), 64'd0);

    // boundary: bank strobe lands in the cycle the counter hits the limit
    i_m0_reg_address = 32'h20; i_m0_reg_out_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("bnd_req_held", 64'(o_reg_out_req), 64'd1);
      check("bnd_no_tmo",   64'(o_timeout_stb), 64'd0);
    end
    i_reg_out_rdy_stb = 1'b1; i_reg_out_data = 32'hDEAD_BEEF; i_reg_invalid_addr = 1'b0;
    tick();
    i_reg_out_rdy_stb = 1'b0; i_reg_out_data = '0; i_m0_reg_out_req = 1'b0;
    check("bnd_stb",  64'(o_m0_reg_out_rdy_stb), 64'd1);
    check("bnd_tmo",  64'(o_timeout_stb), 64'd0);
    check("bnd_data", 64'(o_m0_reg_out_data), 64'hDEAD_BEEF);
    check("bnd_inv",  64'(o_m0_reg_invalid_addr), 64'd0);
    tick();
    check("bnd_data_held", 64'(o_m0_reg_out_data), 64'hDEAD_BEEF);

    // timeout: m0 read never answered
    i_m0_reg_address = 32'h24; i_m0_reg_out_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("tmo_wait_stb", 64'(o_m0_reg_out_rdy_stb), 64'd0);
      check("tmo_wait_tmo", 64'(o_timeout_stb), 64'd0);
    end
    tick();
    i_m0_reg_out_req = 1'b0;
    check("tmo_stb",   64'(o_m0_reg_out_rdy_stb), 64'd1);
    check("tmo_pulse", 64'(o_timeout_stb), 64'd1);
    check("tmo_data",  64'(o_m0_reg_out_data), 64'd0);
    check("tmo_inv",   64'(o_m0_reg_invalid_addr), 64'd1);
    check("tmo_grant", 64'(o_grant), 64'd0);
    tick();
    check("tmo_pulse_once", 64'(o_timeout_stb), 64'd0);

    // m1 write after the timeout, then stray acks in RELEASE and IDLE
    i_m1_reg_address = 32'h30; i_m1_reg_in_data = 32'h1234_5678; i_m1_reg_in_rdy = 1'b1;
    tick();
    check("post_grant", 64'(o_grant), 64'd2);
    check("post_wdata", 64'(o_reg_in_data), 64'h1234_5678);
    i_reg_in_ack_stb = 1'b1;
    tick();
    i_m1_reg_in_rdy = 1'b0;
    check("post_ack", 64'(o_m1_reg_in_ack_stb), 64'd1);
    check("post_tmo", 64'(o_timeout_stb), 64'd0);
    tick();
    check("stray_rel_m1", 64'(o_m1_reg_in_ack_stb), 64'd0);
    check("stray_rel_m0", 64'(o_m0_reg_in_ack_stb), 64'd0);
    tick();
    i_reg_in_ack_stb = 1'b0;
    check("stray_idle_m1", 64'(o_m1_reg_in_ack_stb), 64'd0);
    check("stray_idle_grant", 64'(o_grant), 64'd0);

    // reset while an m1 read is pending
    snap1 = m1_rd_cnt;
    i_m1_reg_address = 32'h40; i_m1_reg_out_req = 1'b1;
    tick();
    check("rstg_grant", 64'(o_grant), 64'd2);
    tick();
    rst = 1'b1;
    tick();
    check("rstg_grant0", 64'(o_grant), 64'd0);
    check("rstg_req0",   64'(o_reg_out_req), 64'd0);
    check("rstg_addr0",  64'(o_reg_address), 64'd0);
    check("rstg_m1stb",  64'(o_m1_reg_out_rdy_stb), 64'd0);
    check("rstg_m0data", 64'(o_m0_reg_out_data), 64'd0);
    rst = 1'b0; i_m1_reg_out_req = 1'b0;
    i_m0_reg_address = 32'h50; i_m0_reg_in_rdy = 1'b1;
    i_m1_reg_address = 32'h60; i_m1_reg_in_rdy = 1'b1;
    tick();
    check("rstg_first_m0", 64'(o_grant), 64'd1);
    i_reg_in_ack_stb = 1'b1;
    tick();
    i_reg_in_ack_stb = 1'b0; i_m0_reg_in_rdy = 1'b0;
    tick();
    tick();
    check("rstg_then_m1", 64'(o_grant), 64'd2);
    i_reg_in_ack_stb = 1'b1;
    tick();
    i_reg_in_ack_stb = 1'b0; i_m1_reg_in_rdy = 1'b0;
    tick(); tick();
    check("rstg_no_m1_rd", 64'(m1_rd_cnt - snap1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
